// File: rtl/dmac_ioregister_mbox_if.sv
// Burst bus bundle between the AXI slave-side burst master and the mailbox.
// bresp/rresp only exist when DMAC_IOREG_MBOX_RESP_EN is defined.
interface dmac_ioregister_mbox_if #(
    parameter int unsigned W_D     = 32,
    parameter int unsigned W_EXT_A = 32,
    parameter int unsigned W_BLEN  = 8
);
    logic               awvalid;
    logic [W_EXT_A-1:0] awaddr;
    logic [W_BLEN-1:0]  awlen;
    logic               awready;
    logic               wvalid;
    logic [W_D-1:0]     wdata;
    logic               wlast;
    logic               wready;
    logic               bvalid;
    logic               bready;
    logic               arvalid;
    logic [W_EXT_A-1:0] araddr;
    logic [W_BLEN-1:0]  arlen;
    logic               arready;
    logic               rvalid;
    logic [W_D-1:0]     rdata;
    logic               rlast;
    logic               rready;
`ifdef DMAC_IOREG_MBOX_RESP_EN
    logic [1:0]         bresp;
    logic [1:0]         rresp;
`endif

    modport master (
        output awvalid, awaddr, awlen, input awready,
        output wvalid, wdata, wlast, input wready,
        input bvalid, output bready,
        output arvalid, araddr, arlen, input arready,
        input rvalid, rdata, rlast, output rready
`ifdef DMAC_IOREG_MBOX_RESP_EN
        , input bresp, rresp
`endif
    );

    modport slave (
        input awvalid, awaddr, awlen, output awready,
        input wvalid, wdata, wlast, output wready,
        output bvalid, input bready,
        input arvalid, araddr, arlen, output arready,
        output rvalid, rdata, rlast, input rready
`ifdef DMAC_IOREG_MBOX_RESP_EN
        , output bresp, rresp
`endif
    );
endinterface

// File: rtl/dmac_ioregister_mbox.sv
// Multi-channel mailbox: per channel a down FIFO (bus write -> thread) and an
// up FIFO (thread -> bus read). Optional DMAC_IOREG_MBOX_RESP_EN adds bresp/rresp
// reporting SLVERR for bursts addressed to a nonexistent channel.
module dmac_ioregister_mbox #(
    parameter int unsigned W_D            = 32,
    parameter int unsigned W_EXT_A        = 32,
    parameter int unsigned W_BLEN         = 8,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned W_CH           = 2,
    parameter int unsigned CH_ADDR_LSB    = 12,
    parameter int unsigned FIFO_DEPTH_LOG = 3
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic [W_CH-1:0]      coram_ch,
    input  logic [W_D-1:0]       coram_d,
    input  logic                 coram_we,
    input  logic                 coram_re,
    output logic [W_D-1:0]       coram_q,
    output logic                 coram_empty,
    output logic                 coram_full,
    dmac_ioregister_mbox_if.slave bus
);
    // Every encodable channel index gets a slot; slots >= NUM_CH are tied off
    // as permanently empty/full so invalid indices need no special muxing.
    localparam int unsigned NUM_SLOT = 2 ** W_CH;
    localparam int unsigned DEPTH    = 2 ** FIFO_DEPTH_LOG;
    localparam int unsigned W_CNT    = W_BLEN + 1;
    localparam int unsigned W_OCC    = FIFO_DEPTH_LOG + 1;

    typedef enum logic [1:0] {StIdle, StWrite, StWresp, StRead} state_e;

    state_e            state_q;
    logic              last_grant_rd_q;
    logic              awready_q;
    logic              arready_q;
    logic              bvalid_q;
    logic [W_CH-1:0]   ch_q;
    logic [W_CNT-1:0]  cnt_q;

    logic [W_D-1:0]    down_head [NUM_SLOT];
    logic [W_D-1:0]    up_head [NUM_SLOT];
    logic [NUM_SLOT-1:0] down_empty, down_full, up_empty, up_full;

    logic              ch_valid, grant_wr, last_beat;
    logic              wready, rvalid, wbeat, rbeat;
    logic [W_CH-1:0]   aw_ch, ar_ch;
    logic              unused_bus;

    assign ch_valid  = 32'(ch_q) < NUM_CH;
    assign aw_ch     = bus.awaddr[CH_ADDR_LSB +: W_CH];
    assign ar_ch     = bus.araddr[CH_ADDR_LSB +: W_CH];
    // On a tie, grant the opposite of the previous grant.
    assign grant_wr  = bus.awvalid && (!bus.arvalid || last_grant_rd_q);
    assign last_beat = cnt_q == W_CNT'(1);

    // Data phase opens the cycle after the address pulse.
    assign wready = (state_q == StWrite) && !awready_q && (!ch_valid || !down_full[ch_q]);
    assign rvalid = (state_q == StRead) && !arready_q && (!ch_valid || !up_empty[ch_q]);
    assign wbeat  = wready && bus.wvalid;
    assign rbeat  = rvalid && bus.rready;

    assign bus.awready = awready_q;
    assign bus.arready = arready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.wready  = wready;
    assign bus.rvalid  = rvalid;
    assign bus.rdata   = (rvalid && ch_valid) ? up_head[ch_q] : '0;
    assign bus.rlast   = rvalid && last_beat;

`ifdef DMAC_IOREG_MBOX_RESP_EN
    // ch_q is stable for the whole burst, so the response is too.
    assign bus.bresp = ch_valid ? 2'b00 : 2'b10;
    assign bus.rresp = ch_valid ? 2'b00 : 2'b10;
`endif

    assign coram_q     = down_empty[coram_ch] ? '0 : down_head[coram_ch];
    assign coram_empty = down_empty[coram_ch];
    assign coram_full  = up_full[coram_ch];

    // wlast is ignored; burst end comes from the beat counter.
    assign unused_bus = ^{bus.wlast, bus.awaddr, bus.araddr};

    // Burst FSM with registered handshake outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q         <= StIdle;
            last_grant_rd_q <= 1'b1;
            awready_q       <= 1'b0;
            arready_q       <= 1'b0;
            bvalid_q        <= 1'b0;
            ch_q            <= '0;
            cnt_q           <= '0;
        end else begin
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant_wr) begin
                        ch_q            <= aw_ch;
                        cnt_q           <= W_CNT'(bus.awlen) + W_CNT'(1);
                        awready_q       <= 1'b1;
                        last_grant_rd_q <= 1'b0;
                        state_q         <= StWrite;
                    end else if (bus.arvalid) begin
                        ch_q            <= ar_ch;
                        cnt_q           <= W_CNT'(bus.arlen) + W_CNT'(1);
                        arready_q       <= 1'b1;
                        last_grant_rd_q <= 1'b1;
                        state_q         <= StRead;
                    end
                end
                StWrite: begin
                    if (wbeat) begin
                        cnt_q <= cnt_q - W_CNT'(1);
                        if (last_beat) begin
                            bvalid_q <= 1'b1;
                            state_q  <= StWresp;
                        end
                    end
                end
                StWresp: begin
                    if (bus.bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                StRead: begin
                    if (rbeat) begin
                        cnt_q <= cnt_q - W_CNT'(1);
                        if (last_beat) state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_SLOT; c++) begin : g_ch
        if (c < NUM_CH) begin : g_fifo
            logic [W_D-1:0]            down_mem [DEPTH];
            logic [W_D-1:0]            up_mem [DEPTH];
            logic [FIFO_DEPTH_LOG-1:0] down_wp_q, down_rp_q, up_wp_q, up_rp_q;
            logic [W_OCC-1:0]          down_cnt_q, up_cnt_q;
            logic                      down_push, down_pop, up_push, up_pop;

            // Full/empty gate each operation using pre-cycle occupancy.
            assign down_push = wbeat && ch_valid && (ch_q == W_CH'(c));
            assign down_pop  = coram_re && (coram_ch == W_CH'(c)) && !down_empty[c];
            assign up_push   = coram_we && (coram_ch == W_CH'(c)) && !up_full[c];
            assign up_pop    = rbeat && ch_valid && (ch_q == W_CH'(c));

            assign down_empty[c] = down_cnt_q == '0;
            assign down_full[c]  = down_cnt_q == W_OCC'(DEPTH);
            assign up_empty[c]   = up_cnt_q == '0;
            assign up_full[c]    = up_cnt_q == W_OCC'(DEPTH);
            assign down_head[c]  = down_mem[down_rp_q];
            assign up_head[c]    = up_mem[up_rp_q];

            // Storage is unreset; occupancy masks stale contents.
            always_ff @(posedge ACLK) begin
                if (down_push) down_mem[down_wp_q] <= bus.wdata;
                if (up_push)   up_mem[up_wp_q]     <= coram_d;
            end

            // Pointers and occupancy for both directions.
            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    down_wp_q  <= '0;
                    down_rp_q  <= '0;
                    down_cnt_q <= '0;
                    up_wp_q    <= '0;
                    up_rp_q    <= '0;
                    up_cnt_q   <= '0;
                end else begin
                    if (down_push) down_wp_q <= down_wp_q + 1'b1;
                    if (down_pop)  down_rp_q <= down_rp_q + 1'b1;
                    if (down_push && !down_pop)      down_cnt_q <= down_cnt_q + 1'b1;
                    else if (!down_push && down_pop) down_cnt_q <= down_cnt_q - 1'b1;
                    if (up_push) up_wp_q <= up_wp_q + 1'b1;
                    if (up_pop)  up_rp_q <= up_rp_q + 1'b1;
                    if (up_push && !up_pop)      up_cnt_q <= up_cnt_q + 1'b1;
                    else if (!up_push && up_pop) up_cnt_q <= up_cnt_q - 1'b1;
                end
            end
        end else begin : g_none
            assign down_head[c]  = '0;
            assign up_head[c]    = '0;
            assign down_empty[c] = 1'b1;
            assign down_full[c]  = 1'b1;
            assign up_empty[c]   = 1'b1;
            assign up_full[c]    = 1'b1;
        end
    end
endmodule
